// File: rtl/game_pkg.sv
// Shared definitions for the game input path: key FSM state codes, key bit indices
// and a width helper used to validate counter sizing at elaboration.
package game_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DB_DN = 3'd1;
  localparam logic [2:0] HELD  = 3'd2;
  localparam logic [2:0] DB_UP = 3'd3;
  localparam logic [2:0] LOCK  = 3'd4;

  localparam int unsigned KEY_UP = 1;
  localparam int unsigned KEY_DN = 0;

  function automatic logic fits_width(input int unsigned val, input int unsigned w);
    if (w >= 32) return 1'b1;
    return (val >> w) == 0;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One key: 2-flop synchronizer, debounce/lock FSM and, with BTN_AUTOREPEAT_EN,
// the hold-to-repeat counter. Emits a one-cycle pulse request and the debounced level.
module btn_channel
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
`ifdef BTN_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
`endif
  parameter int unsigned CNT_W        = 25
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic power_i,
  input  logic key_ni,
  output logic req_o,
  output logic pressed_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_last;
  logic             db_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], key_ni};
    end
  end

  assign s        = sync_q[1];
  assign cnt_last = (cnt_q == DB_LAST);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Every state transition clears the counter so each state counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = DB_DN;
          cnt_d   = '0;
        end
      end
      DB_DN: begin
        if (s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          cnt_d = '0;
          if (power_i) begin
            state_d = HELD;
            db_req  = 1'b1;
          end else begin
            state_d = LOCK;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!power_i) begin
          state_d = LOCK;
          cnt_d   = '0;
        end else if (s) begin
          state_d = DB_UP;
          cnt_d   = '0;
        end
      end
      DB_UP: begin
        if (!s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOCK: begin
        if (!s) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pressed_o = (state_q == HELD) || (state_q == DB_UP);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_RATE - 1);

  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rfirst_q, rfirst_d;
  logic             rpt_req;

  // rfirst selects the initial delay until the first repeat has fired.
  always_comb begin
    rcnt_d   = rcnt_q;
    rfirst_d = rfirst_q;
    rpt_req  = 1'b0;
    if (state_q == DB_DN) begin
      rcnt_d   = '0;
      rfirst_d = 1'b1;
    end else if ((state_q == HELD) && power_i) begin
      if (rcnt_q == (rfirst_q ? RPT_FIRST : RPT_NEXT)) begin
        rpt_req  = 1'b1;
        rcnt_d   = '0;
        rfirst_d = 1'b0;
      end else begin
        rcnt_d = (rcnt_q == '1) ? rcnt_q : rcnt_q + 1'b1;
      end
    end else begin
      rcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b1;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
    end
  end

  assign req_o = db_req | rpt_req;
`else
  assign req_o = db_req;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw active-low up/down keys into one-cycle active-low move pulses.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat in each key channel.
module button_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 10000000,
  parameter int unsigned CNT_W        = 25
) (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       power,
  input  logic [1:0] key_n,
  output logic [1:0] button,
  output logic [1:0] pressed
);

  if ((DEBOUNCE_CYC < 2) || !fits_width(DEBOUNCE_CYC, CNT_W) ||
      !fits_width(REPEAT_DELAY, CNT_W) || !fits_width(REPEAT_RATE, CNT_W)) begin : g_cfg_err
    $error("button_conditioner: DEBOUNCE_CYC < 2 or CNT_W too narrow for counters");
  end

  logic [1:0] req;
  logic [1:0] button_q, button_d;

  btn_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
`ifdef BTN_AUTOREPEAT_EN
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
`endif
    .CNT_W       (CNT_W)
  ) u_up (
    .clk_i    (cin),
    .rst_ni   (rst_n),
    .power_i  (power),
    .key_ni   (key_n[KEY_UP]),
    .req_o    (req[KEY_UP]),
    .pressed_o(pressed[KEY_UP])
  );

  btn_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
`ifdef BTN_AUTOREPEAT_EN
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
`endif
    .CNT_W       (CNT_W)
  ) u_dn (
    .clk_i    (cin),
    .rst_ni   (rst_n),
    .power_i  (power),
    .key_ni   (key_n[KEY_DN]),
    .req_o    (req[KEY_DN]),
    .pressed_o(pressed[KEY_DN])
  );

  // Simultaneous requests cancel each other; the channels carry on regardless.
  always_comb begin
    button_d         = '1;
    button_d[KEY_UP] = ~(req[KEY_UP] & ~req[KEY_DN] & power);
    button_d[KEY_DN] = ~(req[KEY_DN] & ~req[KEY_UP] & power);
  end

  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      button_q <= '1;
    end else begin
      button_q <= button_d;
    end
  end

  assign button = button_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model feeds an expected-pulse
// queue; a separate monitor pops and compares whenever a pulse appears.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       cin = 1'b0;
  logic       rst_n;
  logic       power;
  logic [1:0] key_n;
  logic [1:0] button;
  logic [1:0] pressed;

  button_conditioner #(
    .DEBOUNCE_CYC(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CNT_W       (8)
  ) dut (
    .cin    (cin),
    .rst_n  (rst_n),
    .power  (power),
    .key_n  (key_n),
    .button (button),
    .pressed(pressed)
  );

  always #5 cin = ~cin;

  int cyc = 0;
  always @(posedge cin) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } pulse_t;

  pulse_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: per key, run lengths of the synchronized level plus held/locked flags.
  logic [1:0] h1 = 2'b11, h2 = 2'b11, ms;
  bit   held[2], locked[2], prev_s[2], rseen[2], mreq[2];
  int   lowrun[2], highrun[2], ht[2];
  pulse_t mp;

  always @(negedge cin) begin
    if (!rst_n) begin
      h1 = 2'b11;
      h2 = 2'b11;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
        held[i] = 0; locked[i] = 0; prev_s[i] = 1; rseen[i] = 0;
        lowrun[i] = 0; highrun[i] = 0; ht[i] = 0;
      end
    end else begin
      ms = h2;
      h2 = h1;
      h1 = key_n;
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (pressed[i] !== held[i]) begin
          fails++;
          $display("FAIL pressed[%0d] at cycle %0d: got %b, required %b", i, cyc, pressed[i], held[i]);
        end
        mreq[i] = 0;
        if (ms[i]) begin highrun[i]++; lowrun[i] = 0; end
        else       begin lowrun[i]++;  highrun[i] = 0; end
        if (locked[i]) begin
          if (highrun[i] == D) locked[i] = 0;
        end else if (!held[i]) begin
          if (lowrun[i] == D + 1) begin
            if (power) begin
              mreq[i] = 1; held[i] = 1; ht[i] = 0; rseen[i] = 0;
            end else begin
              locked[i] = 1; highrun[i] = 0;
            end
          end
        end else if (!prev_s[i] && !power) begin
          held[i] = 0; locked[i] = 1; highrun[i] = 0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (!prev_s[i]) begin
            ht[i]++;
            if (ht[i] == (rseen[i] ? RR : RD)) begin
              mreq[i] = 1; ht[i] = 0; rseen[i] = 1;
            end
          end else begin
            ht[i] = 0;
          end
`endif
          if (highrun[i] == D + 1) held[i] = 0;
        end
        prev_s[i] = ms[i];
      end
      if (mreq[0] != mreq[1]) begin
        mp.cyc = cyc + 1;
        mp.val = mreq[1] ? 2'b01 : 2'b10;
        exp_q.push_back(mp);
      end
    end
  end

  // Monitor: every observed pulse is matched against the queue head.
  int npulse = 0;
  int last_pc = -1;
  logic [1:0] last_pv = 2'b11;
  pulse_t me;

  always @(negedge cin) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        me = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_pulse: button stayed 11, required %b at cycle %0d", me.val, me.cyc);
      end
      if (button != 2'b11) begin
        npulse++;
        last_pc = cyc;
        last_pv = button;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_pulse: button=%b at cycle %0d, required 11", button, cyc);
        end else begin
          me = exp_q.pop_front();
          if (me.cyc != cyc || me.val != button) begin
            fails++;
            $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d", button, cyc, me.val, me.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cin);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  int t0, n0;
  int rrun[2];

  initial begin
    rst_n = 1'b0;
    power = 1'b1;
    key_n = 2'b11;
    tick(3);
    chk("reset_button", int'(button), 3);
    chk("reset_pressed", int'(pressed), 0);
    rst_n = 1'b1;
    tick(10);

    // Clean press on up
    n0 = npulse; key_n[1] = 1'b0; t0 = cyc;
    tick(12);
    chk("clean_count", npulse - n0, 1);
    chk("clean_latency", last_pc - t0, 7);
    chk("clean_value", int'(last_pv), 1);
    key_n = 2'b11; tick(12);

    // Bounce on down
    n0 = npulse;
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(3);
    key_n[0] = 1'b1; tick(12);
    chk("bounce_count", npulse - n0, 0);
    chk("bounce_pressed", int'(pressed), 0);

    // Simultaneous press
    n0 = npulse; key_n = 2'b00; t0 = cyc;
    tick(7);
    chk("simul_pressed", int'(pressed), 3);
    tick(5);
    chk("simul_count", npulse - n0, 0);
    key_n = 2'b11; tick(12);

    // Long hold on up
    n0 = npulse; key_n[1] = 1'b0; t0 = cyc;
    tick(50);
`ifdef BTN_AUTOREPEAT_EN
    chk("hold_count", npulse - n0, 4);
    chk("hold_last", last_pc - t0, 43);
`else
    chk("hold_count", npulse - n0, 1);
    chk("hold_last", last_pc - t0, 7);
`endif
    key_n = 2'b11; tick(20);

    // Power lock on down
    n0 = npulse; power = 1'b0; key_n[0] = 1'b0;
    tick(20);
    power = 1'b1;
    tick(10);
    chk("lock_count", npulse - n0, 0);
    key_n[0] = 1'b1; tick(8);
    key_n[0] = 1'b0; t0 = cyc;
    tick(10);
    chk("unlock_count", npulse - n0, 1);
    chk("unlock_latency", last_pc - t0, 7);
    key_n = 2'b11; tick(12);

    // Reset mid-hold
    key_n[1] = 1'b0;
    tick(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_button", int'(button), 3);
    chk("midreset_pressed", int'(pressed), 0);
    tick(2);
    n0 = npulse; rst_n = 1'b1; t0 = cyc;
    tick(10);
    chk("postreset_count", npulse - n0, 1);
    chk("postreset_latency", last_pc - t0, 7);
    key_n = 2'b11; tick(12);

    // Randomized key activity
    rrun[0] = 0; rrun[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rrun[i] == 0) begin
          key_n[i] = ~key_n[i];
          rrun[i] = int'($urandom_range(1, 9));
          if ($urandom_range(0, 3) == 0) rrun[i] += 12;
        end
        rrun[i]--;
      end
      tick(1);
    end
    key_n = 2'b11;
    tick(40);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
